ga_parent_select: RTL

Consumer end of the fitness result handshake (`fit_valid`/`fit_chrom`/`fit_score`/`fit_ack`), sitting between the fitness stage and crossover. Per generation it:
- collects POP_SIZE scored chromosomes into a local population store;
- tracks the best chromosome and flags a solution when a score reaches the configured maximum;
- otherwise issues POP_SIZE/2 parent pairs to crossover, chosen by LFSR-driven binary tournament.

---
 rtl/ga_parent_select.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/ga_parent_select.sv
// ga_parent_select
//   Parent selection stage of the GA pipeline. Each generation it collects
//   POP_SIZE scored chromosomes from the fitness stage and tracks the best
//   one. If any score reaches the configured maximum it flags a solution and
//   ends the generation. Otherwise it issues POP_SIZE/2 parent pairs to
//   crossover, each parent the winner of an LFSR-driven binary tournament.
//
// Ports
//   clk, sw_rst          clock, synchronous active-high reset
//   sel_enable           starts a generation (honoured in IDLE only)
//   cnfg_max_fit_score   solution threshold
//   fit_valid/fit_chrom/fit_score/fit_ack
//                        fitness result handshake (fit_ack is a 1-cycle pulse)
//   par_valid/par_chrom_a/par_chrom_b/par_ack
//                        parent pair handshake towards crossover
//   best_chrom/best_score
//                        best chromosome of the current generation
//   sol_found            sticky solution flag
//   gen_done             1-cycle end-of-generation pulse
module ga_parent_select #(
  parameter int          CHROM_MAX_W = 32,
  parameter int          FIT_SCORE_W = 16,
  parameter int          POP_SIZE    = 8,
  parameter int          POP_IDX_W   = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   sw_rst,
  input  logic                   sel_enable,
  input  logic [FIT_SCORE_W-1:0] cnfg_max_fit_score,
  input  logic                   fit_valid,
  input  logic [CHROM_MAX_W-1:0] fit_chrom,
  input  logic [FIT_SCORE_W-1:0] fit_score,
  output logic                   fit_ack,
  output logic                   par_valid,
  output logic [CHROM_MAX_W-1:0] par_chrom_a,
  output logic [CHROM_MAX_W-1:0] par_chrom_b,
  input  logic                   par_ack,
  output logic [CHROM_MAX_W-1:0] best_chrom,
  output logic [FIT_SCORE_W-1:0] best_score,
  output logic                   sol_found,
  output logic                   gen_done
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SELECT, S_DONE} state_t;

  localparam int                   CNT_W     = POP_IDX_W + 1;
  localparam logic [CNT_W-1:0]     POP_FULL  = CNT_W'(POP_SIZE);
  localparam logic [CNT_W-1:0]     POP_LAST  = CNT_W'(POP_SIZE - 1);
  localparam logic [POP_IDX_W-1:0] PAIR_LAST = POP_IDX_W'(POP_SIZE / 2 - 1);

  state_t                 state_q, state_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
  logic [POP_IDX_W-1:0]   pair_cnt_q, pair_cnt_d;
  logic                   fit_ack_q, fit_ack_d;
  logic                   par_valid_q, par_valid_d;
  logic [CHROM_MAX_W-1:0] par_chrom_a_q, par_chrom_a_d;
  logic [CHROM_MAX_W-1:0] par_chrom_b_q, par_chrom_b_d;
  logic [CHROM_MAX_W-1:0] best_chrom_q, best_chrom_d;
  logic [FIT_SCORE_W-1:0] best_score_q, best_score_d;
  logic                   sol_found_q, sol_found_d;
  logic                   gen_done_q, gen_done_d;

  logic [CHROM_MAX_W-1:0] pop_chrom_q [POP_SIZE];
  logic [FIT_SCORE_W-1:0] pop_score_q [POP_SIZE];

  logic                   capture;
  logic [POP_IDX_W-1:0]   wr_idx;
  logic [POP_IDX_W-1:0]   cand0, cand1, cand2, cand3;
  logic [POP_IDX_W-1:0]   win_a, win_b;

  // Binary tournament: higher score wins, a tie goes to the lower index.
  function automatic logic [POP_IDX_W-1:0] tourney(
    input logic [POP_IDX_W-1:0]   ia,
    input logic [POP_IDX_W-1:0]   ib,
    input logic [FIT_SCORE_W-1:0] sa,
    input logic [FIT_SCORE_W-1:0] sb
  );
    if (sa > sb) return ia;
    if (sb > sa) return ib;
    return (ia < ib) ? ia : ib;
  endfunction

  // A new result is taken only while the previous ack pulse is low, which
  // gives the capture/ack alternation when fit_valid is held high.
  assign capture = (state_q == S_COLLECT) && fit_valid && !fit_ack_q &&
                   (wr_cnt_q != POP_FULL);
  assign wr_idx  = wr_cnt_q[POP_IDX_W-1:0];

  assign cand0 = lfsr_q[POP_IDX_W-1:0];
  assign cand1 = lfsr_q[2*POP_IDX_W-1 -: POP_IDX_W];
  assign cand2 = lfsr_q[3*POP_IDX_W-1 -: POP_IDX_W];
  assign cand3 = lfsr_q[4*POP_IDX_W-1 -: POP_IDX_W];
  assign win_a = tourney(cand0, cand1, pop_score_q[cand0], pop_score_q[cand1]);
  assign win_b = tourney(cand2, cand3, pop_score_q[cand2], pop_score_q[cand3]);

  always_comb begin
    state_d       = state_q;
    lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    wr_cnt_d      = wr_cnt_q;
    pair_cnt_d    = pair_cnt_q;
    fit_ack_d     = capture;
    par_valid_d   = par_valid_q;
    par_chrom_a_d = par_chrom_a_q;
    par_chrom_b_d = par_chrom_b_q;
    best_chrom_d  = best_chrom_q;
    best_score_d  = best_score_q;
    sol_found_d   = sol_found_q;

    case (state_q)
      S_IDLE: begin
        if (sel_enable) begin
          wr_cnt_d     = '0;
          pair_cnt_d   = '0;
          best_chrom_d = '0;
          best_score_d = '0;
          sol_found_d  = 1'b0;
          state_d      = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (capture) begin
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
          if (fit_score > best_score_q) begin
            best_chrom_d = fit_chrom;
            best_score_d = fit_score;
          end
          if (fit_score >= cnfg_max_fit_score) begin
            sol_found_d = 1'b1;
          end
          // Without a solution, selection starts right after the last
          // capture. With one, COLLECT lingers a cycle so gen_done follows
          // the final fit_ack pulse.
          if (wr_cnt_q == POP_LAST && !sol_found_d) begin
            state_d = S_SELECT;
          end
        end else if (wr_cnt_q == POP_FULL) begin
          state_d = sol_found_q ? S_DONE : S_SELECT;
        end
      end

      S_SELECT: begin
        // With no pair pending, run both tournaments on the current LFSR.
        if (!par_valid_q) begin
          par_chrom_a_d = pop_chrom_q[win_a];
          par_chrom_b_d = pop_chrom_q[win_b];
          par_valid_d   = 1'b1;
        end else if (par_ack) begin
          par_valid_d = 1'b0;
          pair_cnt_d  = pair_cnt_q + POP_IDX_W'(1);
          if (pair_cnt_q == PAIR_LAST) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    gen_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state_q       <= S_IDLE;
      lfsr_q        <= LFSR_SEED;
      wr_cnt_q      <= '0;
      pair_cnt_q    <= '0;
      fit_ack_q     <= 1'b0;
      par_valid_q   <= 1'b0;
      par_chrom_a_q <= '0;
      par_chrom_b_q <= '0;
      best_chrom_q  <= '0;
      best_score_q  <= '0;
      sol_found_q   <= 1'b0;
      gen_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      wr_cnt_q      <= wr_cnt_d;
      pair_cnt_q    <= pair_cnt_d;
      fit_ack_q     <= fit_ack_d;
      par_valid_q   <= par_valid_d;
      par_chrom_a_q <= par_chrom_a_d;
      par_chrom_b_q <= par_chrom_b_d;
      best_chrom_q  <= best_chrom_d;
      best_score_q  <= best_score_d;
      sol_found_q   <= sol_found_d;
      gen_done_q    <= gen_done_d;
    end
  end

  // Population store; contents are only meaningful after a full collection,
  // so it needs no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      pop_chrom_q[wr_idx] <= fit_chrom;
      pop_score_q[wr_idx] <= fit_score;
    end
  end

  assign fit_ack     = fit_ack_q;
  assign par_valid   = par_valid_q;
  assign par_chrom_a = par_chrom_a_q;
  assign par_chrom_b = par_chrom_b_q;
  assign best_chrom  = best_chrom_q;
  assign best_score  = best_score_q;
  assign sol_found   = sol_found_q;
  assign gen_done    = gen_done_q;

endmodule
